// File: rtl/cpu_mem_pkg.sv
// Shared types and sizing for the main-memory port arbiter.
package cpu_mem_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int LINE_WORDS = 4;
  localparam int LINE_OFF_W = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BURST = 2'd1,
    D_BURST = 2'd2,
    D_WRITE = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(LINE_WORDS - 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side signals of the shared memory port.
interface mem_port_arbiter_if;
  import cpu_mem_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // slave: the arbiter; master: caches plus memory around it
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, i_done,
    output d_gnt, d_rvalid, d_rdata, d_done,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_done,
    input  d_gnt, d_rvalid, d_rdata, d_done,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin pick; a = I side, b = D side.
module rr_arb2 (
  input  logic clock,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic take,
  output logic gnt_a,
  output logic gnt_b
);

  // 0 = a granted last, so b wins the first conflict out of reset
  logic last_b;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (req_a && req_b) begin
      gnt_a = last_b;
      gnt_b = !last_b;
    end else begin
      gnt_a = req_a;
      gnt_b = req_b;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_b <= 1'b0;
    end else if (take) begin
      last_b <= gnt_b;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-wide memory port between I-cache refills and D-cache
// refills/write-throughs, one memory transaction per word.
//
// state   | meaning
// IDLE    | no transaction; arbitrate pending requests
// I_BURST | I-side line refill, word cnt outstanding
// D_BURST | D-side line refill, word cnt outstanding
// D_WRITE | D-side single-word write outstanding
module mem_port_arbiter
  import cpu_mem_pkg::*;
(
  input logic              clock,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  state_t                  state, state_nxt;
  logic [LINE_OFF_W-1:0]   cnt, cnt_nxt;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    gnt_i, gnt_d, take, last_word;

  logic                    mem_req, mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    i_gnt, i_rvalid, i_done;
  logic                    d_gnt, d_rvalid, d_done;
  logic [DATA_W-1:0]       i_rdata, d_rdata;

  rr_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .req_a (bus.i_req),
    .req_b (bus.d_req),
    .take  (take),
    .gnt_a (gnt_i),
    .gnt_b (gnt_d)
  );

  assign last_word = (cnt == LINE_OFF_W'(LINE_WORDS - 1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (gnt_i) begin
          take      = 1'b1;
          state_nxt = I_BURST;
        end else if (gnt_d) begin
          take      = 1'b1;
          state_nxt = bus.d_we ? D_WRITE : D_BURST;
        end
      end
      I_BURST, D_BURST: begin
        mem_req  = 1'b1;
        mem_addr = addr_q | ADDR_W'(cnt);
        if (bus.mem_ack) begin
          cnt_nxt = cnt + LINE_OFF_W'(1);
          if (last_word) state_nxt = IDLE;
        end
      end
      D_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (bus.mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      i_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      i_done   <= 1'b0;
      d_gnt    <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_done   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      i_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      i_done   <= 1'b0;
      d_gnt    <= 1'b0;
      d_rvalid <= 1'b0;
      d_done   <= 1'b0;
      if (state == IDLE) begin
        if (gnt_i) begin
          i_gnt  <= 1'b1;
          addr_q <= line_base(bus.i_addr);
        end else if (gnt_d) begin
          d_gnt   <= 1'b1;
          addr_q  <= bus.d_we ? bus.d_addr : line_base(bus.d_addr);
          wdata_q <= bus.d_wdata;
        end
      end
      // read data and done are registered, so they trail each ack by a cycle
      if (bus.mem_ack) begin
        case (state)
          I_BURST: begin
            i_rvalid <= 1'b1;
            i_rdata  <= bus.mem_rdata;
            i_done   <= last_word;
          end
          D_BURST: begin
            d_rvalid <= 1'b1;
            d_rdata  <= bus.mem_rdata;
            d_done   <= last_word;
          end
          D_WRITE: d_done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.i_gnt     = i_gnt;
  assign bus.i_rvalid  = i_rvalid;
  assign bus.i_rdata   = i_rdata;
  assign bus.i_done    = i_done;
  assign bus.d_gnt     = d_gnt;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.d_rdata   = d_rdata;
  assign bus.d_done    = d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: expectations queued at request time, popped as the
// arbiter grants, issues memory transactions and returns data/done.
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  typedef struct {
    bit          side;   // 0 = I, 1 = D
    bit          rv;
    bit          dn;
    logic [15:0] data;
    int          lat;    // cycles after grant, -1 = not checked
  } out_t;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;
  int   wait_mode = 0;   // >=0 fixed wait cycles per word, <0 random 0..5
  int   wcnt = 0;
  bit   prev_req = 1'b0;

  out_t exp_out[$];
  mem_t exp_mem[$];
  bit   exp_gnt[$];

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  function automatic int pick_wait();
    if (wait_mode < 0) return int'($urandom_range(0, 5));
    return wait_mode;
  endfunction

  function automatic logic [127:0] outs();
    return {56'h0, bus.i_gnt, bus.i_rvalid, bus.i_rdata, bus.i_done,
            bus.d_gnt, bus.d_rvalid, bus.d_rdata, bus.d_done,
            bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata};
  endfunction

  function automatic void push_refill(input bit side, input logic [15:0] addr, input int w);
    logic [15:0] base;
    base = addr & 16'hFFFC;
    exp_gnt.push_back(side);
    for (int k = 0; k < 4; k++) begin
      exp_mem.push_back('{1'b0, base | 16'(k), 16'h0});
      exp_out.push_back('{side, 1'b1, k == 3, mem_fn(base | 16'(k)),
                          (w < 0) ? -1 : (k + 1) * (w + 1)});
    end
  endfunction

  function automatic void push_write(input logic [15:0] addr, input logic [15:0] wdata, input int w);
    exp_gnt.push_back(1'b1);
    exp_mem.push_back('{1'b1, addr, wdata});
    exp_out.push_back('{1'b1, 1'b0, 1'b1, 16'h0, (w < 0) ? -1 : w + 1});
  endfunction

  // memory model: fixed or random wait states, checks every requested cycle
  initial begin
    mem_t m;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clock);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'($urandom);
      if (bus.mem_req && !reset) begin
        if (exp_mem.size() == 0) begin
          check_eq("mem_unexpected", bus.mem_req, 0);
        end else begin
          m = exp_mem[0];
          check_eq("mem_we", bus.mem_we, m.we);
          check_eq("mem_addr", bus.mem_addr, m.addr);
          if (m.we) check_eq("mem_wdata", bus.mem_wdata, m.wdata);
          if (wcnt == 0) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem_fn(bus.mem_addr);
            void'(exp_mem.pop_front());
            wcnt = pick_wait();
          end else begin
            wcnt--;
          end
        end
      end else begin
        wcnt = pick_wait();
      end
    end
  end

  // output monitor
  always @(negedge clock) begin : mon
    out_t       e;
    logic [2:0] kind;
    logic [15:0] data;
    bit         side, i_act, d_act;
    if (!reset) begin
      if (bus.i_gnt || bus.d_gnt) begin
        if (exp_gnt.size() == 0) check_eq("gnt_unexpected", {bus.i_gnt, bus.d_gnt}, 0);
        else check_eq("gnt_side", bus.d_gnt, exp_gnt.pop_front());
        check_eq("mem_req_gap", prev_req, 0);
        gnt_cyc = cyc;
      end
      i_act = bus.i_gnt | bus.i_rvalid | bus.i_done;
      d_act = bus.d_gnt | bus.d_rvalid | bus.d_done;
      if (i_act || d_act) check_eq("side_excl", i_act & d_act, 0);
      if (bus.i_rvalid || bus.i_done || bus.d_rvalid || bus.d_done) begin
        side = bus.d_rvalid | bus.d_done;
        kind = side ? {1'b1, bus.d_rvalid, bus.d_done} : {1'b0, bus.i_rvalid, bus.i_done};
        data = side ? bus.d_rdata : bus.i_rdata;
        if (exp_out.size() == 0) begin
          check_eq("out_unexpected", kind, 0);
        end else begin
          e = exp_out.pop_front();
          check_eq("out_kind", kind, {e.side, e.rv, e.dn});
          if (e.rv) check_eq("rdata", data, e.data);
          if (e.lat >= 0) check_eq("latency", cyc - gnt_cyc, e.lat);
        end
      end
    end
    prev_req = bus.mem_req;
  end

  task automatic drive_i(input logic [15:0] addr, input bit drop);
    int n;
    bus.i_req  = 1'b1;
    bus.i_addr = addr;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!bus.i_gnt && n < 300);
    check_eq("i_gnt_seen", bus.i_gnt, 1);
    bus.i_addr = ~addr;
    if (drop) bus.i_req = 1'b0;
    n = 0;
    while (!bus.i_done && n < 300) begin @(posedge clock); #1; n++; end
    check_eq("i_done_seen", bus.i_done, 1);
    bus.i_req = 1'b0;
  endtask

  task automatic drive_d(input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    int n;
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!bus.d_gnt && n < 300);
    check_eq("d_gnt_seen", bus.d_gnt, 1);
    bus.d_we    = ~we;
    bus.d_addr  = ~addr;
    bus.d_wdata = ~wdata;
    n = 0;
    while (!bus.d_done && n < 300) begin @(posedge clock); #1; n++; end
    check_eq("d_done_seen", bus.d_done, 1);
    bus.d_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] a;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset_outs", outs(), 0);
    reset = 1'b0;

    // conflicts after reset: D wins, I follows; second conflict still D first
    wait_mode = 0;
    push_refill(1'b1, 16'h2005, 0);
    push_refill(1'b0, 16'h0101, 0);
    fork
      drive_d(1'b0, 16'h2005, 16'h0);
      drive_i(16'h0101, 1'b0);
    join
    push_refill(1'b1, 16'h2A0C, 0);
    push_refill(1'b0, 16'h0F0E, 0);
    fork
      drive_d(1'b0, 16'h2A0C, 16'h0);
      drive_i(16'h0F0E, 1'b0);
    join

    // lone write with 3 wait cycles, then a conflict that I must win
    wait_mode = 3;
    push_write(16'h1234, 16'hBEEF, 3);
    drive_d(1'b1, 16'h1234, 16'hBEEF);
    wait_mode = 1;
    push_refill(1'b0, 16'h0777, 1);
    push_refill(1'b1, 16'h4444, 1);
    fork
      drive_d(1'b0, 16'h4444, 16'h0);
      drive_i(16'h0777, 1'b0);
    join

    // lone zero-wait I refill
    wait_mode = 0;
    push_refill(1'b0, 16'h0043, 0);
    drive_i(16'h0043, 1'b0);

    // random wait states
    wait_mode = -1;
    for (int r = 0; r < 4; r++) begin
      a = 16'($urandom);
      push_refill(r[0], a, -1);
      if (r[0]) drive_d(1'b0, a, 16'h0);
      else drive_i(a, 1'b0);
    end

    // request dropped after grant
    wait_mode = 1;
    push_refill(1'b0, 16'h0C0D, 1);
    drive_i(16'h0C0D, 1'b1);

    // reset during the second word of a D refill with an I request pending
    wait_mode = 0;
    @(posedge clock); #1;
    push_refill(1'b1, 16'h3008, 0);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h3008;
    n = 0;
    do begin @(posedge clock); #1; n++; end while (!bus.d_gnt && n < 50);
    check_eq("rst_d_gnt", bus.d_gnt, 1);
    bus.i_req = 1'b1; bus.i_addr = 16'h0200;
    n = 0;
    while (!bus.d_rvalid && n < 50) begin @(posedge clock); #1; n++; end
    check_eq("rst_d_word0", bus.d_rvalid, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check_eq("rst_mid_outs", outs(), 0);
    exp_out.delete();
    exp_mem.delete();
    exp_gnt.delete();
    bus.d_req = 1'b0;
    reset = 1'b0;
    push_refill(1'b0, 16'h0200, 0);
    @(posedge clock); #1;
    check_eq("rst_regrant", bus.i_gnt, 1);
    n = 0;
    while (!bus.i_done && n < 50) begin @(posedge clock); #1; n++; end
    check_eq("rst_i_done", bus.i_done, 1);
    bus.i_req = 1'b0;

    repeat (4) @(posedge clock);
    #1;
    check_eq("out_left", exp_out.size(), 0);
    check_eq("mem_left", exp_mem.size(), 0);
    check_eq("gnt_left", exp_gnt.size(), 0);
    check_eq("idle_outs", outs() & ~128'h0, {56'h0, 1'b0, 1'b0, bus.i_rdata, 1'b0,
             1'b0, 1'b0, bus.d_rdata, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
